// File: rtl/cpu_pkg.sv
// Shared Mini-SRC definitions: instruction opcodes, ALU codes, control-unit
// state encoding, instruction classes and the per-class last execute state.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SHR = 4'd4,
    ALU_SHL = 4'd5,
    ALU_ROR = 4'd6,
    ALU_ROL = 4'd7
  } alu_op_e;

  // E0..E5 must stay consecutive: the sequencer steps through them by +1.
  typedef enum logic [3:0] {
    ST_RESET = 4'd0,
    ST_IDLE  = 4'd1,
    ST_F0    = 4'd2,
    ST_F1    = 4'd3,
    ST_F2    = 4'd4,
    ST_F3    = 4'd5,
    ST_E0    = 4'd6,
    ST_E1    = 4'd7,
    ST_E2    = 4'd8,
    ST_E3    = 4'd9,
    ST_E4    = 4'd10,
    ST_E5    = 4'd11,
    ST_HALT  = 4'd12
  } state_e;

  typedef enum logic [3:0] {
    CLS_ALU     = 4'd0,
    CLS_IMM     = 4'd1,
    CLS_LDI     = 4'd2,
    CLS_LD      = 4'd3,
    CLS_ST      = 4'd4,
    CLS_BR      = 4'd5,
    CLS_NOP     = 4'd6,
    CLS_HALT    = 4'd7,
    CLS_ILLEGAL = 4'd8
  } instr_class_e;

  function automatic state_e last_exec_state(input instr_class_e cls);
    state_e last;
    case (cls)
      CLS_ALU, CLS_IMM, CLS_LDI: last = ST_E2;
      CLS_LD:                    last = ST_E5;
      CLS_ST:                    last = ST_E4;
      CLS_BR:                    last = ST_E3;
      default:                   last = ST_E0;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath signal bundle: the control unit is the master,
// the datapath/RAM/CON FF side is the slave.
interface control_unit_if;
  logic        in_run;
  logic [31:0] in_ir;
  logic        in_branch;
  logic [3:0]  out_alu_opcode;
  logic out_reg_clear, out_mdr_select, out_inc_pc, out_gra, out_grb, out_grc, out_ba_read;
  logic out_regfile_read, out_hi_read, out_lo_read, out_z_hi_read, out_z_lo_read;
  logic out_pc_read, out_mdr_read, out_inport_read, out_c_read, out_mem_read;
  logic out_regfile_write, out_hi_write, out_lo_write, out_z_write, out_pc_write;
  logic out_mdr_write, out_ir_write, out_y_write, out_mar_write, out_mem_write;
  logic out_con_write, out_halted, out_illegal;

  modport master (
    input  in_run, in_ir, in_branch,
    output out_alu_opcode,
    output out_reg_clear, out_mdr_select, out_inc_pc, out_gra, out_grb, out_grc, out_ba_read,
    output out_regfile_read, out_hi_read, out_lo_read, out_z_hi_read, out_z_lo_read,
    output out_pc_read, out_mdr_read, out_inport_read, out_c_read, out_mem_read,
    output out_regfile_write, out_hi_write, out_lo_write, out_z_write, out_pc_write,
    output out_mdr_write, out_ir_write, out_y_write, out_mar_write, out_mem_write,
    output out_con_write, out_halted, out_illegal
  );

  modport slave (
    output in_run, in_ir, in_branch,
    input  out_alu_opcode,
    input  out_reg_clear, out_mdr_select, out_inc_pc, out_gra, out_grb, out_grc, out_ba_read,
    input  out_regfile_read, out_hi_read, out_lo_read, out_z_hi_read, out_z_lo_read,
    input  out_pc_read, out_mdr_read, out_inport_read, out_c_read, out_mem_read,
    input  out_regfile_write, out_hi_write, out_lo_write, out_z_write, out_pc_write,
    input  out_mdr_write, out_ir_write, out_y_write, out_mar_write, out_mem_write,
    input  out_con_write, out_halted, out_illegal
  );
endinterface

// File: rtl/cu_decode.sv
// Opcode -> instruction class and ALU code. With CU_BRANCH_EN undefined the
// br opcode decodes as illegal.
module cu_decode
  import cpu_pkg::*;
(
  input  logic [4:0]   opcode,
  output instr_class_e instr_class,
  output alu_op_e      alu_op
);

  // Pure table lookup; unsupported opcodes fall to the illegal class.
  always_comb begin
    instr_class = CLS_ILLEGAL;
    alu_op      = ALU_ADD;
    case (opcode)
      OP_LD:   instr_class = CLS_LD;
      OP_LDI:  instr_class = CLS_LDI;
      OP_ST:   instr_class = CLS_ST;
      OP_ADD:  begin instr_class = CLS_ALU; alu_op = ALU_ADD; end
      OP_SUB:  begin instr_class = CLS_ALU; alu_op = ALU_SUB; end
      OP_AND:  begin instr_class = CLS_ALU; alu_op = ALU_AND; end
      OP_OR:   begin instr_class = CLS_ALU; alu_op = ALU_OR;  end
      OP_SHR:  begin instr_class = CLS_ALU; alu_op = ALU_SHR; end
      OP_SHL:  begin instr_class = CLS_ALU; alu_op = ALU_SHL; end
      OP_ROR:  begin instr_class = CLS_ALU; alu_op = ALU_ROR; end
      OP_ROL:  begin instr_class = CLS_ALU; alu_op = ALU_ROL; end
      OP_ADDI: begin instr_class = CLS_IMM; alu_op = ALU_ADD; end
      OP_ANDI: begin instr_class = CLS_IMM; alu_op = ALU_AND; end
      OP_ORI:  begin instr_class = CLS_IMM; alu_op = ALU_OR;  end
`ifdef CU_BRANCH_EN
      OP_BR:   instr_class = CLS_BR;
`endif
      OP_NOP:  instr_class = CLS_NOP;
      OP_HALT: instr_class = CLS_HALT;
      default: instr_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Mini-SRC hardwired control unit: fetch F0-F3, then E0.. per instruction class.
// Build macro CU_BRANCH_EN enables the br instruction (otherwise br is illegal).
module control_unit
  import cpu_pkg::*;
(
  input  logic           clk,
  input  logic           in_reset_n,
  control_unit_if.master cu
);

  state_e       state_r;
  instr_class_e cls_s;
  alu_op_e      alu_s;
  state_e       last_s;

  cu_decode u_decode (
    .opcode      (cu.in_ir[31:27]),
    .instr_class (cls_s),
    .alu_op      (alu_s)
  );

  assign last_s = last_exec_state(cls_s);

  // Sequencer; in_run is only looked at on instruction boundaries.
  always_ff @(posedge clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_r <= ST_RESET;
    end else begin
      case (state_r)
        ST_RESET: state_r <= ST_IDLE;
        ST_IDLE:  state_r <= cu.in_run ? ST_F0 : ST_IDLE;
        ST_F0:    state_r <= ST_F1;
        ST_F1:    state_r <= ST_F2;
        ST_F2:    state_r <= ST_F3;
        ST_F3:    state_r <= ST_E0;
        ST_E0, ST_E1, ST_E2, ST_E3, ST_E4, ST_E5: begin
          if (state_r == last_s || state_r == ST_E5) begin
            if (cls_s == CLS_HALT)  state_r <= ST_HALT;
            else if (cu.in_run)     state_r <= ST_F0;
            else                    state_r <= ST_IDLE;
          end else begin
            state_r <= state_e'(state_r + 4'd1);
          end
        end
        ST_HALT:  state_r <= ST_HALT;
        default:  state_r <= ST_RESET;
      endcase
    end
  end

  // Control word decode from the current state (IR is stable throughout E*).
  always_comb begin
    cu.out_alu_opcode    = ALU_ADD;
    cu.out_reg_clear     = 1'b0;
    cu.out_mdr_select    = 1'b0;
    cu.out_inc_pc        = 1'b0;
    cu.out_gra           = 1'b0;
    cu.out_grb           = 1'b0;
    cu.out_grc           = 1'b0;
    cu.out_ba_read       = 1'b0;
    cu.out_regfile_read  = 1'b0;
    cu.out_hi_read       = 1'b0;
    cu.out_lo_read       = 1'b0;
    cu.out_z_hi_read     = 1'b0;
    cu.out_z_lo_read     = 1'b0;
    cu.out_pc_read       = 1'b0;
    cu.out_mdr_read      = 1'b0;
    cu.out_inport_read   = 1'b0;
    cu.out_c_read        = 1'b0;
    cu.out_mem_read      = 1'b0;
    cu.out_regfile_write = 1'b0;
    cu.out_hi_write      = 1'b0;
    cu.out_lo_write      = 1'b0;
    cu.out_z_write       = 1'b0;
    cu.out_pc_write      = 1'b0;
    cu.out_mdr_write     = 1'b0;
    cu.out_ir_write      = 1'b0;
    cu.out_y_write       = 1'b0;
    cu.out_mar_write     = 1'b0;
    cu.out_mem_write     = 1'b0;
    cu.out_con_write     = 1'b0;
    cu.out_halted        = 1'b0;
    cu.out_illegal       = 1'b0;
    case (state_r)
      ST_RESET: cu.out_reg_clear = 1'b1;
      ST_F0: begin
        cu.out_pc_read   = 1'b1;
        cu.out_mar_write = 1'b1;
        cu.out_inc_pc    = 1'b1;
        cu.out_pc_write  = 1'b1;
      end
      ST_F1: cu.out_mem_read = 1'b1;
      ST_F2: begin
        cu.out_mdr_select = 1'b1;
        cu.out_mdr_write  = 1'b1;
      end
      ST_F3: begin
        cu.out_mdr_read = 1'b1;
        cu.out_ir_write = 1'b1;
      end
      ST_E0: begin
        case (cls_s)
          CLS_ALU, CLS_IMM: begin
            cu.out_grb = 1'b1; cu.out_regfile_read = 1'b1; cu.out_y_write = 1'b1;
          end
          CLS_LDI, CLS_LD, CLS_ST: begin
            cu.out_grb = 1'b1; cu.out_ba_read = 1'b1; cu.out_y_write = 1'b1;
          end
          CLS_BR: begin
            cu.out_gra = 1'b1; cu.out_regfile_read = 1'b1;
`ifdef CU_BRANCH_EN
            cu.out_con_write = 1'b1;
`endif
          end
          CLS_ILLEGAL: cu.out_illegal = 1'b1;
          default: cu.out_illegal = 1'b0;
        endcase
      end
      ST_E1: begin
        case (cls_s)
          CLS_ALU: begin
            cu.out_grc = 1'b1; cu.out_regfile_read = 1'b1;
            cu.out_alu_opcode = alu_s; cu.out_z_write = 1'b1;
          end
          CLS_IMM: begin
            cu.out_c_read = 1'b1; cu.out_alu_opcode = alu_s; cu.out_z_write = 1'b1;
          end
          CLS_LDI, CLS_LD, CLS_ST: begin
            cu.out_c_read = 1'b1; cu.out_z_write = 1'b1;
          end
          CLS_BR: begin
            cu.out_pc_read = 1'b1; cu.out_y_write = 1'b1;
          end
          default: cu.out_z_write = 1'b0;
        endcase
      end
      ST_E2: begin
        case (cls_s)
          CLS_ALU, CLS_IMM, CLS_LDI: begin
            cu.out_gra = 1'b1; cu.out_z_lo_read = 1'b1; cu.out_regfile_write = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            cu.out_z_lo_read = 1'b1; cu.out_mar_write = 1'b1;
          end
          CLS_BR: begin
            cu.out_c_read = 1'b1; cu.out_z_write = 1'b1;
          end
          default: cu.out_z_write = 1'b0;
        endcase
      end
      ST_E3: begin
        case (cls_s)
          CLS_LD: cu.out_mem_read = 1'b1;
          CLS_ST: begin
            cu.out_gra = 1'b1; cu.out_regfile_read = 1'b1; cu.out_mdr_write = 1'b1;
          end
          // Taken branch loads PC from Z; not taken leaves everything idle.
          CLS_BR: begin
            cu.out_z_lo_read = cu.in_branch;
            cu.out_pc_write  = cu.in_branch;
          end
          default: cu.out_mem_read = 1'b0;
        endcase
      end
      ST_E4: begin
        case (cls_s)
          CLS_LD: begin
            cu.out_mdr_select = 1'b1; cu.out_mdr_write = 1'b1;
          end
          CLS_ST: cu.out_mem_write = 1'b1;
          default: cu.out_mem_write = 1'b0;
        endcase
      end
      ST_E5: begin
        case (cls_s)
          CLS_LD: begin
            cu.out_mdr_read = 1'b1; cu.out_gra = 1'b1; cu.out_regfile_write = 1'b1;
          end
          default: cu.out_regfile_write = 1'b0;
        endcase
      end
      ST_HALT: cu.out_halted = 1'b1;
      default: cu.out_halted = 1'b0;
    endcase
  end

endmodule
